// File: rtl/uart_rx.sv
// uart_rx: 8N1 RS-232 receiver, LSB first.
// Three-flop synchroniser on the line, falling-edge start detect, mid-bit
// sampling of start, 8 data bits and stop. A good byte is presented with a
// one-cycle rx_done pulse. A low stop bit gives a one-cycle frame_err pulse
// and the byte is dropped.
module uart_rx #(
    parameter int BAUD_END = 5207,
    parameter int BAUD_MID = BAUD_END / 2
) (
    input  logic       s_clk,
    input  logic       s_rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [12:0] END_C = 13'(BAUD_END);
    localparam logic [12:0] MID_C = 13'(BAUD_MID);

    logic        rx_r1_q, rx_r2_q, rx_r3_q;
    logic [1:0]  state_q, state_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_err_q, frame_err_d;

    logic sample;
    logic start_edge;

    assign sample     = (baud_cnt_q == MID_C);
    assign start_edge = !rx_r2_q && rx_r3_q;

    // Next-state logic: bit timing, FSM, shift register and output pulses.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        baud_cnt_d  = (baud_cnt_q == END_C) ? 13'd0 : baud_cnt_q + 13'd1;

        case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                if (sample) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_r2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {rx_r2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (rx_r2_q) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    // Leave at mid stop bit so a gapless next start is caught.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts from zero for every frame, including one that
        // begins right after returning to IDLE.
        if (state_q == IDLE || state_d == IDLE) baud_cnt_d = 13'd0;
    end

    // State registers; sync flops reset high so reset release is not a start.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_r1_q     <= 1'b1;
            rx_r2_q     <= 1'b1;
            rx_r3_q     <= 1'b1;
            state_q     <= IDLE;
            baud_cnt_q  <= 13'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_r1_q     <= rs232_rx;
            rx_r2_q     <= rx_r1_q;
            rx_r3_q     <= rx_r2_q;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames driven by a behavioural serial sender; each
// frame pushes its expected outcome (byte or framing error, and the cycle
// the pulse is due for ideal bit time) into a queue that a separate monitor
// pops whenever rx_done or frame_err is seen.
module tb_uart_rx;

    localparam int BE      = 52;
    localparam int BM      = BE / 2;
    localparam int BT      = BE + 1;
    localparam int LATENCY = 3 + BM + 9 * BT;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       s_clk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       q[$];
    logic [7:0] model_last = 8'h00;

    uart_rx #(.BAUD_END(BE), .BAUD_MID(BM)) dut (
        .s_clk    (s_clk),
        .s_rst_n  (s_rst_n),
        .rs232_rx (rs232_rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 s_clk = ~s_clk;

    always @(posedge s_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold the line at b for bt clocks; always returns at posedge + 1.
    task automatic drive_bit(input logic b, input int bt);
        rs232_rx = b;
        repeat (bt) begin
            @(posedge s_clk);
            #1;
        end
    endtask

    // Send one frame with the given stop-bit level and record what must come out.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
        exp_t e;
        e.err  = !stop;
        e.data = d;
        e.cyc  = (bt == BT) ? cyc + 1 + LATENCY : -1;
        q.push_back(e);
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
        drive_bit(stop, bt);
    endtask

    // Monitor: every pulse consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge s_clk);
            if (!s_rst_n) begin
                model_last = 8'h00;
            end else if (rx_done || frame_err) begin
                if (rx_done && frame_err) chk("pulse_exclusive", 32'(rx_done & frame_err), 0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, rx_done, frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
                    if (e.cyc >= 0) chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    if (!e.err) begin
                        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                        model_last = e.data;
                    end else begin
                        chk("rx_data_hold", {24'd0, rx_data}, {24'd0, model_last});
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] partial;
        int         rates[3];
        rates[0] = BT; rates[1] = 51; rates[2] = 55;

        // Reset state
        repeat (3) @(posedge s_clk);
        #1;
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_rx_done", {31'd0, rx_done}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_rx_busy", {31'd0, rx_busy}, 0);
        s_rst_n = 1'b1;
        drive_bit(1'b1, 20);
        chk("idle_busy", {31'd0, rx_busy}, 0);

        // Single frame, exact latency
        send_frame(8'h55, 1'b1, BT);
        chk("busy_after_frame", {31'd0, rx_busy}, 0);
        drive_bit(1'b1, 10);

        // Back to back, no idle gap
        send_frame(8'hA3, 1'b1, BT);
        send_frame(8'h0F, 1'b1, BT);
        drive_bit(1'b1, 30);

        // Short low glitch: START aborts at mid-bit
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 6);
        chk("glitch_busy_high", {31'd0, rx_busy}, 1);
        drive_bit(1'b1, 20);
        chk("glitch_busy_low", {31'd0, rx_busy}, 0);
        send_frame(8'h81, 1'b1, BT);
        drive_bit(1'b1, 10);

        // Framing error keeps previous byte
        send_frame(8'h12, 1'b1, BT);
        send_frame(8'hFF, 1'b0, BT);
        drive_bit(1'b1, 60);
        chk("rx_data_after_ferr", {24'd0, rx_data}, 32'h12);

        // Break: line held low yields one frame_err only
        send_frame(8'h00, 1'b0, BT);
        drive_bit(1'b0, 3 * BT);
        drive_bit(1'b1, BT);
        chk("break_busy", {31'd0, rx_busy}, 0);

        // Reset in the middle of data bit 4 of 0x6B
        partial = 8'h6B;
        drive_bit(1'b0, BT);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], BT);
        drive_bit(partial[4], BM);
        s_rst_n = 1'b0;
        #1;
        chk("midrst_rx_data", {24'd0, rx_data}, 0);
        chk("midrst_rx_busy", {31'd0, rx_busy}, 0);
        chk("midrst_pulses", {30'd0, rx_done, frame_err}, 0);
        rs232_rx = 1'b1;
        repeat (3) @(posedge s_clk);
        #1;
        s_rst_n = 1'b1;
        drive_bit(1'b1, BT);
        send_frame(8'h3C, 1'b1, BT);
        drive_bit(1'b1, 10);

        // Sender at nominal, fast and slow bit time
        for (int r = 0; r < 3; r++) begin
            send_frame(8'h00, 1'b1, rates[r]);
            send_frame(8'hFF, 1'b1, rates[r]);
            for (int n = 0; n < 20; n++) begin
                b = 8'($urandom_range(0, 255));
                send_frame(b, 1'b1, rates[r]);
                if (r == 0) drive_bit(1'b1, $urandom_range(0, 3));
            end
            drive_bit(1'b1, 40);
        end

        // Random good/bad frames
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'($urandom_range(0, 3) != 0), BT);
            drive_bit(1'b1, $urandom_range(1, 8));
        end

        drive_bit(1'b1, 600);
        chk("queue_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
